// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
//   imem_req   : request valid, held until imem_ack
//   imem_addr  : word address, stable while imem_req is high
//   imem_ack   : imem_rdata valid this cycle, completes the request
//   imem_rdata : fetched instruction word
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps a single request outstanding to instruction
// memory, buffers returned words in a 2-entry queue and presents the head instruction plus its
// decoded fields downstream. Jumps/branches resolved on the head redirect the PC and flush the
// wrong-path words.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   imem                   : instruction-memory req/ack bus (master side)
//   stall                  : downstream cannot take the head this cycle
//   pc_src_jal/pc_src_jr   : head is j/jal, head is jr
//   branch_taken           : head is a taken beq
//   rs_data                : jr target
//   instr_valid/instr/...  : head entry, its pc, pc+4 and its field slices
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                pc_src_jal,
  input  logic                pc_src_jr,
  input  logic                branch_taken,
  input  logic [31:0]         rs_data,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc,
  output logic [31:0]         pc_plus4,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [15:0]         imm,
  output logic [25:0]         jaddr
);

  if (QDEPTH != 2) begin : gen_qdepth_check
    $error("fetch_unit: QDEPTH must be 2");
  end

  typedef enum logic [1:0] {StWait, StReq, StDrop} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       drop_addr_q, drop_addr_d;  // address of the abandoned wrong-path request
  logic [1:0]        count_q, count_d;
  logic [1:0][31:0]  ent_instr_q, ent_instr_d;
  logic [1:0][31:0]  ent_pc_q, ent_pc_d;

  logic        pop, redirect, push;
  logic [1:0]  count_pop;
  logic [31:0] target;
  logic [31:0] br_off;

  assign pop       = instr_valid & ~stall;
  assign redirect  = pop & (pc_src_jr | pc_src_jal | branch_taken);
  assign count_pop = count_q - {1'b0, pop};
  assign br_off    = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    if (pc_src_jr) begin
      target = rs_data;
    end else if (pc_src_jal) begin
      target = {pc_plus4[31:28], jaddr, 2'b00};
    end else begin
      target = pc_plus4 + br_off;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      count_q     <= '0;
      ent_instr_q <= '0;
      ent_pc_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      ent_instr_q <= ent_instr_d;
      ent_pc_q    <= ent_pc_d;
    end
  end

  // Next-state and fetch PC
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    unique case (state_q)
      StWait: begin
        if (redirect) begin
          state_d    = StReq;
          fetch_pc_d = target;
        end else if (count_pop <= 2'd1) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect) begin
          fetch_pc_d = target;
          // Unacked request must still complete; its data is dropped in StDrop.
          if (!imem.imem_ack) begin
            state_d     = StDrop;
            drop_addr_d = fetch_pc_q;
          end
        end else if (imem.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_pop == 2'd1) begin
            state_d = StWait;
          end
        end
      end
      StDrop: begin
        if (imem.imem_ack) begin
          state_d = StReq;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Queue update: pop shifts entry 1 to head, push lands after any same-cycle pop.
  always_comb begin
    count_d     = count_q;
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    if (redirect) begin
      count_d     = '0;
      ent_instr_d = '0;
      ent_pc_d    = '0;
    end else begin
      if (pop) begin
        ent_instr_d[0] = ent_instr_q[1];
        ent_pc_d[0]    = ent_pc_q[1];
        ent_instr_d[1] = '0;
        ent_pc_d[1]    = '0;
      end
      count_d = count_pop;
      if (push) begin
        if (count_pop == 2'd0) begin
          ent_instr_d[0] = imem.imem_rdata;
          ent_pc_d[0]    = fetch_pc_q;
        end else begin
          ent_instr_d[1] = imem.imem_rdata;
          ent_pc_d[1]    = fetch_pc_q;
        end
        count_d = count_pop + 2'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    imem.imem_req  = (state_q == StReq) || (state_q == StDrop);
    imem.imem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
    instr_valid    = (count_q != 2'd0);
    instr          = instr_valid ? ent_instr_q[0] : '0;
    instr_pc       = instr_valid ? ent_pc_q[0] : '0;
    pc_plus4       = instr_pc + 32'd4;
  end

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign jaddr  = instr[25:0];

  ack_when_full_a: assert property (@(posedge clk) disable iff (!reset_n)
      !(imem.imem_req && imem.imem_ack && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory with per-address ack latency and a
// minimal control-unit decoder drive the DUT; key cycles and the consumed-pc stream are checked.
module tb_fetch_unit;
  logic        clk;
  logic        reset_n;
  logic        stall, pc_src_jal, pc_src_jr, branch_taken;
  logic [31:0] rs_data;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem         (imem),
    .stall        (stall),
    .pc_src_jal   (pc_src_jal),
    .pc_src_jr    (pc_src_jr),
    .branch_taken (branch_taken),
    .rs_data      (rs_data),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .funct        (funct),
    .imm          (imm),
    .jaddr        (jaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int age      = 0;    // cycles the current request has waited
  logic br_cond     = 1'b1;  // beq compare result, one-shot
  logic force_flags = 1'b0;
  logic ack_force   = 1'b0;
  logic [31:0] consumed[$];
  logic [31:0] exp_log[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0040:           return 32'h1000_FFFE;  // beq imm=-2
      32'h0000_0044, 32'h200:  return 32'h03E0_0008;  // jr $31
      32'h1000_0010:           return 32'h0C00_0100;  // jal 0x100
      default:                 return a | 32'h2000_0000;
    endcase
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    case (a)
      32'h0000_0048: return 3;
      32'h1000_0410: return 50;
      default:       return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory and control-unit models react to the settled DUT outputs.
  task automatic drive();
    imem.imem_ack   = ack_force |
                      (imem.imem_req && (age >= lat_of(imem.imem_addr)));
    imem.imem_rdata = ack_force ? 32'hDEAD_BEEF : word_at(imem.imem_addr);
    pc_src_jal   = force_flags | (instr_valid && (opcode == 6'd2 || opcode == 6'd3));
    pc_src_jr    = force_flags | (instr_valid && opcode == 6'd0 && funct == 6'd8);
    branch_taken = force_flags | (instr_valid && opcode == 6'd4 && br_cond);
    rs_data      = (instr_pc == 32'h44) ? 32'h200 : 32'h1000_0010;
  endtask

  task automatic tick();
    logic was_req, was_ack, was_br;
    if (instr_valid && !stall) consumed.push_back(instr_pc);
    was_req = imem.imem_req;
    was_ack = imem.imem_ack;
    was_br  = branch_taken && instr_valid && !stall;
    @(posedge clk);
    #1;
    if (was_br) br_cond = 1'b0;
    if (was_req && !was_ack) age++;
    else age = 0;
    drive();
  endtask

  task automatic wait_head(input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(instr_valid === 1'b1 && instr_pc === pc) && n < budget) begin
      tick();
      n++;
    end
    check("reach_head", {31'd0, (instr_valid === 1'b1 && instr_pc === pc)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    stall   = 1'b0;
    drive();
    #1 reset_n = 1'b0;
    #1 drive();
    repeat (3) tick();
    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);

    // Release with all redirect flags high while nothing is valid: they must be ignored.
    reset_n     = 1'b1;
    force_flags = 1'b1;
    drive();
    force_flags = 1'b0;
    tick();
    check("c1_req", {31'd0, imem.imem_req}, 32'd1);
    check("c1_addr", imem.imem_addr, 32'h0);
    check("c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("c2_valid", {31'd0, instr_valid}, 32'd1);
    check("c2_pc", instr_pc, 32'h0);
    check("c2_instr", instr, 32'h2000_0000);
    check("c2_opcode", {26'd0, opcode}, 32'h08);
    check("c2_addr", imem.imem_addr, 32'h4);
    tick();
    tick();
    check("c4_pc", instr_pc, 32'h8);
    check("c4_addr", imem.imem_addr, 32'hC);

    // Stall five cycles: queue fills to 2 and the request drops.
    stall = 1'b1;
    tick();
    check("stall1_req", {31'd0, imem.imem_req}, 32'd0);
    check("stall1_pc", instr_pc, 32'h8);
    repeat (4) tick();
    check("stall5_req", {31'd0, imem.imem_req}, 32'd0);
    check("stall5_valid", {31'd0, instr_valid}, 32'd1);
    check("stall5_pc", instr_pc, 32'h8);
    stall = 1'b0;
    tick();
    check("unstall_pc", instr_pc, 32'hC);
    check("unstall_req", {31'd0, imem.imem_req}, 32'd1);
    check("unstall_addr", imem.imem_addr, 32'h10);
    tick();
    check("unstall2_pc", instr_pc, 32'h10);

    // Taken beq at 0x40 back to 0x3C.
    wait_head(32'h40, 100);
    check("beq_opcode", {26'd0, opcode}, 32'h04);
    check("beq_imm", {16'd0, imm}, 32'hFFFE);
    check("beq_pc4", pc_plus4, 32'h44);
    tick();
    check("beq_flush", {31'd0, instr_valid}, 32'd0);
    check("beq_addr", imem.imem_addr, 32'h3C);
    tick();
    check("beq_tgt_pc", instr_pc, 32'h3C);
    tick();
    check("beq2_pc", instr_pc, 32'h40);

    // jr at 0x44 while the 0x48 request is slow: wrong-path request held until acked.
    tick();
    check("jr_pc", instr_pc, 32'h44);
    check("jr_rs", {27'd0, rs}, 32'd31);
    check("jr_funct", {26'd0, funct}, 32'd8);
    check("jr_addr", imem.imem_addr, 32'h48);
    tick();
    check("drop0_valid", {31'd0, instr_valid}, 32'd0);
    check("drop0_req", {31'd0, imem.imem_req}, 32'd1);
    check("drop0_addr", imem.imem_addr, 32'h48);
    tick();
    check("drop1_addr", imem.imem_addr, 32'h48);
    tick();
    check("drop2_addr", imem.imem_addr, 32'h48);
    tick();
    check("drop_done_addr", imem.imem_addr, 32'h200);
    check("drop_done_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("jr_tgt_pc", instr_pc, 32'h200);

    // jr at 0x200 to 0x1000_0010, which holds a jal.
    tick();
    check("jr2_flush", {31'd0, instr_valid}, 32'd0);
    check("jr2_addr", imem.imem_addr, 32'h1000_0010);
    tick();
    check("jal_pc", instr_pc, 32'h1000_0010);
    check("jal_opcode", {26'd0, opcode}, 32'h03);
    check("jal_jaddr", {6'd0, jaddr}, 32'h100);
    check("jal_pc4", pc_plus4, 32'h1000_0014);
    tick();
    check("jal_flush", {31'd0, instr_valid}, 32'd0);
    check("jal_addr", imem.imem_addr, 32'h1000_0400);
    tick();
    check("jal_tgt_pc", instr_pc, 32'h1000_0400);
    check("jal_tgt_instr", instr, 32'h3000_0400);
    check("jal_tgt_shamt", {27'd0, shamt}, 32'd16);
    check("jal_tgt_rd", {27'd0, rd}, 32'd0);
    repeat (3) tick();
    check("seq_pc", instr_pc, 32'h1000_040C);
    tick();
    check("empty_valid", {31'd0, instr_valid}, 32'd0);
    check("slow_req", {31'd0, imem.imem_req}, 32'd1);
    check("slow_addr", imem.imem_addr, 32'h1000_0410);
    tick();

    for (int i = 0; i <= 16; i++) exp_log.push_back(32'(i * 4));
    exp_log.push_back(32'h3C);
    exp_log.push_back(32'h40);
    exp_log.push_back(32'h44);
    exp_log.push_back(32'h200);
    exp_log.push_back(32'h1000_0010);
    exp_log.push_back(32'h1000_0400);
    exp_log.push_back(32'h1000_0404);
    exp_log.push_back(32'h1000_0408);
    exp_log.push_back(32'h1000_040C);
    check("log_len", 32'(consumed.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < consumed.size()) check($sformatf("log[%0d]", i), consumed[i], exp_log[i]);
    end

    // Reset mid-request, then a late ack arrives while in the wait state.
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    ack_force = 1'b1;
    drive();
    repeat (2) tick();
    reset_n = 1'b1;
    drive();
    tick();
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("restart_req", {31'd0, imem.imem_req}, 32'd1);
    check("restart_addr", imem.imem_addr, 32'h0);
    ack_force = 1'b0;
    drive();
    tick();
    check("restart_valid", {31'd0, instr_valid}, 32'd1);
    check("restart_pc", instr_pc, 32'h0);
    check("restart_instr", instr, 32'h2000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of control_unit.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers fetched words in a 2-entry queue and presents the head instruction's decoded fields (opcode/funct/shamt, etc.) to control_unit and the register file.
- Consumes control_unit's PCSrcJal/PCSrcJr and the datapath's taken-branch flag to redirect the PC, flushing wrong-path fetches (no delay slot).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, fetch queue depth (fixed at 2; any other value is a lint error).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid; held until ack.
- imem_addr  out  32  word address; stable while imem_req=1.
- imem_ack  in  1  rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept the head instruction this cycle.
- pc_src_jal  in  1  head is j/jal (from control_unit PCSrcJal).
- pc_src_jr  in  1  head is jr (PCSrcJr).
- branch_taken  in  1  head is beq and comparison true.
- rs_data  in  32  register value for jr.
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of head.
- pc_plus4  out  32  instr_pc+4 (jal link value).
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm  out  16  instr[15:0].
- jaddr  out  26  instr[25:0].

Behaviour:
- Reset (async, while reset_n=0):
  - state=S_WAIT, fetch_pc=RESET_PC, queue count=0, both entries cleared to 0.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - First edge after release: S_WAIT→S_REQ, so imem_req rises one cycle after reset release.
  - Reset asserted mid-request abandons that request; a late ack after reset is ignored because the block is in S_WAIT.
- Field outputs are pure slices of instr. instr=0 whenever instr_valid=0, so field outputs are all 0 then.
- Consume: instr_valid & ~stall. The head pops and entry 1 (if any) shifts to head the same edge.
- Redirect: consume & (pc_src_jr | pc_src_jal | branch_taken).
  - Priority: jr > jal > branch.
  - Targets:
    - jr: rs_data.
    - jal/j: {pc_plus4[31:28], jaddr, 2'b00}.
    - branch: pc_plus4 + (sign-extended imm << 2), 32-bit wrap-around.
  - Flags with instr_valid=0 are ignored.
- imem_req = (state==S_REQ | state==S_DROP). imem_addr = fetch_pc in S_REQ; imem_addr = the held old address in S_DROP.
- States:
  - S_WAIT: no request outstanding. Moves to S_REQ at the edge where count-after-edge ≤ 1.
  - S_REQ: request to fetch_pc outstanding.
    - On ack without redirect: push rdata with its pc (after any same-cycle pop); fetch_pc += 4 (wraps at 2^32). Next state is S_WAIT if count-after-edge = 2, else S_REQ.
    - On ack with redirect: discard rdata, flush, fetch_pc=target, stay S_REQ.
    - No ack, with redirect: flush, fetch_pc=target, go to S_DROP (the old address is held on imem_addr).
  - S_DROP: a wrong-path request is outstanding.
    - On ack: discard rdata, go to S_REQ with the new fetch_pc.
    - A further redirect cannot occur here because the queue is empty.
  - Redirect in S_WAIT: flush, fetch_pc=target, go to S_REQ.
- Flush: count=0, both entries zeroed, instr_valid=0 next cycle. The redirecting instruction itself is consumed.
- Latency: ack at edge N → instr_valid=1 after edge N. Back-to-back single-cycle acks with no stall give one instruction per cycle.
- Count never exceeds 2. Ack while count=2 is impossible by construction; assert in simulation.
- stall with instr_valid=0: no effect.
- Simultaneous ack and pop with count=1: result is count=1, head=old entry 1 or new data in order.

Test Plan:
- Release reset with RESET_PC=0 and memory acking every cycle with rdata=addr|0x2000_0000 → imem_addr 0,4,8,… from cycle 1; instr_valid from cycle 2; instr_pc matches; opcode=6'b001000.
- stall=1 for 5 cycles with always-ack → queue fills to 2, imem_req drops; after stall releases, words emerge in order with no gap or duplicate.
- Head beq at pc 0x40, imm=0xFFFE, branch_taken=1 → next imem_addr=0x3C; queued 0x44 entry flushed and never seen.
- Head jal at pc 0x1000_0010 with jaddr=0x0000100 → redirect to 0x1000_0400; pc_plus4=0x1000_0014.
- jr with rs_data=0x200 while a request to 0x48 is outstanding (ack delayed 3 cycles) → S_DROP holds addr 0x48 until ack; that data is discarded; next request is 0x200.
- Assert reset_n=0 mid-request → imem_req and instr_valid go to 0 immediately; a late ack is ignored; fetch restarts at RESET_PC.
